// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the divide path: FSM state encoding,
// default operand widths and the step-counter width helper.
package arith_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Step counter must hold 0..DIVIDEND_W.
  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/trial_subtractor.sv
// Combinational W-bit subtract with borrow-out; the trial step of the
// restoring divider (borrow_o = 1 means the difference went negative).
module trial_subtractor #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuend_i,
  input  logic [W-1:0] subtrahend_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);

  logic [W:0] diff_ext;

  assign diff_ext = {1'b0, minuend_i} - {1'b0, subtrahend_i};
  assign diff_o   = diff_ext[W-1:0];
  assign borrow_o = diff_ext[W];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Build option DIV_ZERO_DETECT_EN: zero divisor short-cuts IDLE -> DONE and flags div_by_zero.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands latched on the start edge
//   CALC    | one shift/trial-subtract step per cycle, DIVIDEND_W cycles
//   DONE    | results written on entry, done pulses for this one cycle
module seq_divider
  import arith_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = cnt_width(DIVIDEND_W);
  localparam int REM_W = DIVISOR_W + 1;

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [DIVIDEND_W-1:0] qsh_q, qsh_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  remo_q, remo_d;
  logic                  dbz_q, dbz_d;

  logic [REM_W-1:0]      rem_shift;
  logic [REM_W-1:0]      trial_diff;
  logic                  trial_borrow;
  logic [REM_W-1:0]      rem_step;
  logic [DIVIDEND_W-1:0] qsh_step;
  logic                  last_step;

  // The top bit of R is always shifted out before the next trial, so it is
  // never observed; only R' (formed below) needs the extra bit.
  logic                  unused_rem_msb;
  assign unused_rem_msb = rem_q[REM_W-1];

  assign rem_shift = {rem_q[DIVISOR_W-1:0], qsh_q[DIVIDEND_W-1]};

  trial_subtractor #(
    .W (REM_W)
  ) u_trial (
    .minuend_i    (rem_shift),
    .subtrahend_i ({1'b0, dvs_q}),
    .diff_o       (trial_diff),
    .borrow_o     (trial_borrow)
  );

  assign rem_step  = trial_borrow ? rem_shift : trial_diff;
  assign qsh_step  = {qsh_q[DIVIDEND_W-2:0], ~trial_borrow};
  assign last_step = (cnt_q == CNT_W'(DIVIDEND_W - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qsh_d   = qsh_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvs_d = divisor;
          rem_d = '0;
          qsh_d = dividend;
          cnt_d = '0;
`ifdef DIV_ZERO_DETECT_EN
          if (divisor == '0) begin
            state_d = ST_DONE;
            quot_d  = '1;
            remo_d  = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
`else
          state_d = ST_CALC;
`endif
        end
      end

      ST_CALC: begin
        rem_d = rem_step;
        qsh_d = qsh_step;
        cnt_d = cnt_q + CNT_W'(1);
        // Results land on DONE entry so they are valid while done is high.
        if (last_step) begin
          state_d = ST_DONE;
          quot_d  = qsh_step;
          remo_d  = rem_step[DIVISOR_W-1:0];
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      qsh_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      qsh_q   <= qsh_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (default 8/4 widths); honours
// DIV_ZERO_DETECT_EN when the design is built with it.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Drive one start pulse; returns at the negedge of cycle k+1 with operands scrambled.
  task automatic issue(input logic [7:0] dvd, input logic [3:0] dvs);
    @(negedge clk);
    start    = 1'b1;
    dividend = dvd;
    divisor  = dvs;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hA5;
    divisor  = 4'h3;
  endtask

  // Count cycles (relative to the start edge) until done; lat = -1 on timeout.
  task automatic wait_done(input int first_lat, output int lat, output int busy_cycles);
    lat = first_lat;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b q=%0d r=%0d, expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bc;
    issue(8'd200, 4'd7);
    wait_done(1, lat, bc);
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat);
    end
    n_checks++;
    if (bc !== 8) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd28, 4'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder} !== {1'b0, 1'b0, 8'd28, 4'd4}) begin
      n_fail++;
      $display("FAIL basic_after_done: got busy=%b done=%b q=%0d r=%0d expected 0 0 28 4",
               busy, done, quotient, remainder);
    end
  endtask

  task automatic test_vectors();
    int dvd[5] = '{255, 5, 100, 7, 1};
    int dvs[5] = '{15, 9, 9, 1, 15};
    int eq[5]  = '{17, 0, 11, 7, 0};
    int er[5]  = '{0, 5, 1, 0, 1};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      issue(8'(dvd[i]), 4'(dvs[i]));
      wait_done(1, lat, bc);
      n_checks++;
      if (lat !== 9 || quotient !== 8'(eq[i]) || remainder !== 4'(er[i])) begin
        n_fail++;
        $display("FAIL vector_%0d_%0d: got lat=%0d q=%0d r=%0d expected lat=9 q=%0d r=%0d",
                 dvd[i], dvs[i], lat, quotient, remainder, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    issue(8'd200, 4'd7);
    wait_done(1, lat, bc);
    // start during the done cycle must be ignored
    start = 1'b1; dividend = 8'd99; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", busy);
    end
    start = 1'b1; dividend = 8'd100; divisor = 4'd9;
    @(negedge clk);
    start = 1'b0; dividend = 8'h5A; divisor = 4'hC;
    n_checks++;
    if ({busy, quotient, remainder} !== {1'b1, 8'd28, 4'd4}) begin
      n_fail++;
      $display("FAIL b2b_hold_first: got busy=%b q=%0d r=%0d expected 1 28 4",
               busy, quotient, remainder);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({done, quotient, remainder} !== {1'b0, 8'd28, 4'd4}) begin
      n_fail++;
      $display("FAIL b2b_hold_mid: got done=%b q=%0d r=%0d expected 0 28 4",
               done, quotient, remainder);
    end
    wait_done(7, lat, bc);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd11 || remainder !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=9 q=11 r=1",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    issue(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd99; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat, bc);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=9 q=28 r=4",
               lat, quotient, remainder);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL ignore_start_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    int exp_lat, exp_bc;
    logic [12:0] exp_res;
`ifdef DIV_ZERO_DETECT_EN
    exp_lat = 1; exp_bc = 0; exp_res = {8'hFF, 4'd0, 1'b1};
`else
    exp_lat = 9; exp_bc = 8; exp_res = {8'hFF, 4'd4, 1'b0};
`endif
    issue(8'd100, 4'd0);
    wait_done(1, lat, bc);
    n_checks++;
    if (lat !== exp_lat || bc !== exp_bc) begin
      n_fail++;
      $display("FAIL div_zero_timing: got lat=%0d busy_cycles=%0d expected %0d %0d",
               lat, bc, exp_lat, exp_bc);
    end
    n_checks++;
    if ({quotient, remainder, div_by_zero} !== exp_res) begin
      n_fail++;
      $display("FAIL div_zero_result: got q=%h r=%0d dbz=%b expected %h", quotient,
               remainder, div_by_zero, exp_res);
    end
    @(negedge clk);
    n_checks++;
    if ({done, div_by_zero} !== 2'b00) begin
      n_fail++;
      $display("FAIL div_zero_flag_clear: got done=%b dbz=%b expected 0 0", done, div_by_zero);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int n_done;
    issue(8'd200, 4'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got busy=%b done=%b q=%0d r=%0d expected all 0",
               busy, done, quotient, remainder);
    end
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_checks++;
    if (n_done !== 0) begin
      n_fail++; $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", n_done);
    end
    rst = 1'b1; start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_wins_start: got busy=%b done=%b expected 0 0", busy, done);
    end
    issue(8'd200, 4'd7);
    wait_done(1, lat, bc);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd28 || remainder !== 4'd4) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: got lat=%0d q=%0d r=%0d expected lat=9 q=28 r=4",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_sweep();
    int lat, bc;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(8'(a), 4'(b));
        wait_done(1, lat, bc);
        n_checks++;
        if (lat !== 9 || quotient !== 8'(a / b) || remainder !== 4'(a % b)) begin
          n_fail++;
          $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d expected lat=9 q=%0d r=%0d",
                   a, b, lat, quotient, remainder, a / b, a % b);
        end
        n_checks++;
        if ((int'(quotient) * b + int'(remainder)) !== a || int'(remainder) >= b) begin
          n_fail++;
          $display("FAIL sweep_invariant_%0d_%0d: got q=%0d r=%0d", a, b, quotient, remainder);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_div_zero();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider. It is the inverse-direction companion to the team's Vedic multiplier/adder datapath.
- Takes an unsigned dividend and divisor and produces quotient and remainder, one quotient bit per cycle.
- Sits beside the multiplier as the arithmetic unit's divide path, driven by a start/done handshake.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width; must be ≤ DIVIDEND_W.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DIVIDEND_W  unsigned dividend; sampled with start.
- divisor  input  DIVISOR_W  unsigned divisor; sampled with start.
- busy  output  1  high while CALC is active.
- done  output  1  one-cycle pulse; results are valid.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.
- div_by_zero  output  1  divide-by-zero flag, valid with done.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: FSM=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; internal counter and registers 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 at edge k latches operands. The partial remainder R (DIVISOR_W+1 bits) is cleared. The shift register Q is loaded with dividend and the bit counter with 0. Next state is CALC.
  - CALC, per cycle: R' = {R[DIVISOR_W-1:0], Q[MSB]}. Trial T = R' − {0,divisor}.
    - If T is non-negative (no borrow): R ← T and shift 1 into Q LSB.
    - Otherwise: R ← R' and shift 0 into Q LSB.
    - Counter increments. After DIVIDEND_W CALC cycles, go to DONE.
  - DONE: quotient ← Q and remainder ← R[DIVISOR_W-1:0] are written on entry. done=1 for exactly this one cycle. Next state is IDLE.
- Latency: start sampled at edge k → busy high in cycles k+1..k+DIVIDEND_W → done high in cycle k+DIVIDEND_W+1 → IDLE after that.
- busy is low in IDLE and DONE.
- start is ignored while busy=1 or done=1. No queuing; the requester must wait for done.
- quotient and remainder hold their values until the next DONE entry. They are not cleared by a new start.
- Operand inputs are don't-care outside the start edge. Changes during CALC have no effect.
- Arithmetic:
  - Everything is unsigned; there is no overflow, because quotient ≤ dividend fits in DIVIDEND_W.
  - Invariant checked at done: dividend == quotient*divisor + remainder, and remainder < divisor (for divisor≠0).
- Reset mid-operation: rst in any state returns to IDLE on that edge. Outputs go to their reset values and the in-flight result is discarded; no done pulse is produced.
- Simultaneous rst and start: rst wins and start is lost.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined: divisor==0 at start sends IDLE directly to DONE on the next edge, skipping CALC, so done arrives at k+1. Results: quotient = all ones, remainder = 0, div_by_zero = 1 during done. div_by_zero is 0 on every other done.
- Undefined: div_by_zero is tied to 0. Divide-by-zero runs the normal DIVIDEND_W-cycle algorithm and gives its natural result: quotient = all ones, remainder = dividend[DIVISOR_W-1:0].

Decomposition:
- Shared package arith_pkg:
  - FSM state enum (IDLE/CALC/DONE).
  - Default width constants DIVIDEND_W_DEF=8 and DIVISOR_W_DEF=4.
  - Counter width localparam = clog2(DIVIDEND_W+1).
- One sub-module, trial_subtractor: combinational (DIVISOR_W+1)-bit subtract with borrow-out. It is the subtract counterpart of the team adder and is used for the CALC trial step.
- The FSM, counter and shift registers stay in seq_divider.

Test Plan:
- 200 / 7, start at k → busy in k+1..k+8, done at k+9; quotient=28, remainder=4, div_by_zero=0.
- 255/15 → q=17, r=0. Then 5/9 → q=0, r=5. Then back-to-back start issued the cycle after done → second result correct, and the first result is held until the second done.
- start pulsed again during cycle k+3 with 99/3 → ignored; the result is still 200/7 = 28 r 4, done at k+9 only.
- 100/0 with DIV_ZERO_DETECT_EN → done at k+1; q=0xFF, r=0, div_by_zero=1. Without the macro → done at k+9; q=0xFF, r=4, div_by_zero=0.
- rst asserted in cycle k+4 of 200/7 → next cycle busy=0, done=0, q=0, r=0; no done pulse follows. A fresh 200/7 then completes normally.
- Random sweep of all 256×15 nonzero operand pairs → quotient*divisor+remainder == dividend and remainder < divisor for every result.
